// File: rtl/half_mult_sched.sv
// Round-robin scheduler sharing one multicycle half multiplier
// among NUM_REQ requesters; operands held MULT_LAT cycles.
module half_multiplier #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  assign p = a * b;
endmodule

module half_mult_sched #(
  parameter int MULT_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int MULT_LAT   = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*MULT_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*MULT_WIDTH-1:0] req_y,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [MULT_WIDTH-1:0]         resp_prod,
  output logic                          busy,
  output logic [31:0]                   op_count
);
  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant;
  logic [ID_W-1:0]       op_id;
  logic                  grant_vld;
  logic                  accept;
  logic [CNT_W-1:0]      lat_cnt;
  logic [MULT_WIDTH-1:0] op_x;
  logic [MULT_WIDTH-1:0] op_y;
  logic [MULT_WIDTH-1:0] half_prod;
  int                    idx;

  half_multiplier #(
    .W (MULT_WIDTH)
  ) u_mult (
    .a (op_x),
    .b (op_y),
    .p (half_prod)
  );

  // Scan downward so the nearest requester after rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[ID_W'(idx)]) begin
        grant     = ID_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && grant_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_vld) state_nx = CALC;
      CALC:    if (lat_cnt == '0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_x      <= '0;
      op_y      <= '0;
      op_id     <= '0;
      lat_cnt   <= '0;
      rr_ptr    <= '0;
      resp_prod <= '0;
      resp_id   <= '0;
      op_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_x    <= req_x[grant*MULT_WIDTH +: MULT_WIDTH];
            op_y    <= req_y[grant*MULT_WIDTH +: MULT_WIDTH];
            op_id   <= grant;
            lat_cnt <= CNT_W'(MULT_LAT - 1);
            if (grant == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                            rr_ptr <= grant + 1'b1;
          end
        end
        CALC: begin
          if (lat_cnt == '0) begin
            resp_prod <= half_prod;
            resp_id   <= op_id;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) op_count <= op_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_half_mult_sched.sv
// Bench for half_mult_sched: vector table, corner sequences
// and random ops against an arithmetic round-robin model.
module tb_half_mult_sched;
  localparam int MW  = 8;
  localparam int NR  = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [7:0]  resp_prod;
  logic        busy;
  logic [31:0] op_count;

  half_mult_sched #(
    .MULT_WIDTH (MW),
    .NUM_REQ    (NR),
    .MULT_LAT   (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  typedef struct {
    int         id;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] m);
    for (int k = 0; k < NR; k++)
      if (m[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return 0;
  endfunction

  function automatic logic [7:0] model_prod(input logic [31:0] xs,
                                            input logic [31:0] ys,
                                            input int g);
    int a, b;
    a = int'(xs[g*8 +: 8]);
    b = int'(ys[g*8 +: 8]);
    return 8'((a * b) % 256);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_op(input logic [3:0] vm, input logic [31:0] xs,
                        input logic [31:0] ys, input int eg,
                        input logic [7:0] ep, input int hold);
    int c;
    logic [3:0] oh;
    oh = 4'b0001 << eg;
    req_valid  = vm;
    req_x      = xs;
    req_y      = ys;
    resp_ready = 1'b0;
    #1;
    chk("grant", 64'(req_ready), 64'(oh));
    @(posedge clk);
    m_ptr = (eg + 1) % NR;
    @(negedge clk);
    chk("busy_calc", 64'(busy), 64'd1);
    c = 0;
    while (!resp_valid && c < 20) begin
      chk("ready_calc", 64'(req_ready), 64'd0);
      @(negedge clk);
      c++;
    end
    chk("latency", 64'(c), 64'(LAT));
    chk("prod", 64'(resp_prod), 64'(ep));
    chk("id", 64'(resp_id), 64'(eg));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_prod", 64'(resp_prod), 64'(ep));
      chk("hold_id", 64'(resp_id), 64'(eg));
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_cnt", 64'(op_count), 64'(m_cnt));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    m_cnt++;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("done_valid", 64'(resp_valid), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_cnt", 64'(op_count), 64'(m_cnt));
    chk("done_prod", 64'(resp_prod), 64'(ep));
  endtask

  initial begin
    logic [3:0]  vm;
    logic [31:0] xs, ys;
    int          g;
    int          rr_g[5];
    logic [7:0]  rr_p[5];

    vecs[0] = '{1, 8'h03, 8'h05, 8'h0F};
    vecs[1] = '{0, 8'hFF, 8'hFF, 8'h01};
    vecs[2] = '{2, 8'h10, 8'h10, 8'h00};
    vecs[3] = '{3, 8'h00, 8'hAB, 8'h00};
    vecs[4] = '{1, 8'h0C, 8'h0B, 8'h84};
    vecs[5] = '{0, 8'h80, 8'h02, 8'h00};
    vecs[6] = '{2, 8'h07, 8'h25, 8'h03};
    vecs[7] = '{3, 8'hFF, 8'h02, 8'hFE};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_cnt", 64'(op_count), 64'd0);
    chk("rst_prod", 64'(resp_prod), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      xs = $urandom;
      ys = $urandom;
      xs[vecs[i].id*8 +: 8] = vecs[i].x;
      ys[vecs[i].id*8 +: 8] = vecs[i].y;
      run_op(4'b0001 << vecs[i].id, xs, ys, vecs[i].id, vecs[i].p,
             int'($urandom_range(0, 2)));
    end

    // Long backpressure on requester 3
    xs = {8'h0B, 24'h0};
    ys = {8'h0D, 24'h0};
    run_op(4'b1000, xs, ys, 3, 8'h8F, 10);

    // Requester 2 alone, then again with rr_ptr past it
    xs = 32'h0006_0000;
    ys = 32'h0007_0000;
    run_op(4'b0100, xs, ys, 2, 8'h2A, 0);
    run_op(4'b0100, xs, ys, 2, 8'h2A, 1);
    xs = 32'h0900_0000;
    ys = 32'h0300_0000;
    run_op(4'b1111, xs, ys, 3, 8'h1B, 0);

    // Reset in the middle of a calculation
    req_valid = 4'b0100;
    req_x     = 32'h0011_0000;
    req_y     = 32'h0022_0000;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_cnt", 64'(op_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // All four valid: fixed order 0,1,2,3,0
    rr_g = '{0, 1, 2, 3, 0};
    rr_p = '{8'h0C, 8'h15, 8'h20, 8'h2D, 8'h0C};
    for (int i = 0; i < 5; i++)
      run_op(4'b1111, 32'h0504_0302, 32'h0908_0706, rr_g[i], rr_p[i], 0);
    chk("rr_cnt5", 64'(op_count), 64'd5);

    for (int n = 0; n < 40; n++) begin
      vm = 4'($urandom_range(1, 15));
      xs = $urandom;
      ys = $urandom;
      g  = model_grant(vm);
      run_op(vm, xs, ys, g, model_prod(xs, ys, g),
             int'($urandom_range(0, 3)));
    end

    req_valid = '0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
